prf_multiport: RTL and testbench

//  Parametrised multi-ported physical register file for the OoO core, with an integrated per-register ready (busy) table.

---
 rtl/prf_multiport_if.sv | 31 +++
 rtl/prf_multiport.sv | 93 +++++++++
 tb/tb_prf_multiport.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/prf_multiport_if.sv
// Port bundle for the physical register file: read, writeback and allocation
// ports plus the write-conflict flag.
interface prf_multiport_if #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned PHYS_REGS = 64,
  parameter int unsigned PREG_W    = $clog2(PHYS_REGS),
  parameter int unsigned NUM_RD    = 4,
  parameter int unsigned NUM_WR    = 2,
  parameter int unsigned NUM_AL    = 2
);
  logic [NUM_RD*PREG_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_ready;
  logic [NUM_WR-1:0]        wr_en;
  logic [NUM_WR*PREG_W-1:0] wr_addr;
  logic [NUM_WR*DATA_W-1:0] wr_data;
  logic [NUM_AL-1:0]        al_en;
  logic [NUM_AL*PREG_W-1:0] al_addr;
  logic                     wr_conflict;
  logic                     conflict_clr;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, al_en, al_addr, conflict_clr,
    input  rd_data, rd_ready, wr_conflict
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, al_en, al_addr, conflict_clr,
    output rd_data, rd_ready, wr_conflict
  );
endinterface

// File: rtl/prf_multiport.sv
// Multi-ported physical register file with per-register ready table,
// optional write->read bypass and a sticky same-cycle write-conflict flag.
module prf_multiport #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned PHYS_REGS = 64,
  parameter int unsigned PREG_W    = $clog2(PHYS_REGS),
  parameter int unsigned NUM_RD    = 4,
  parameter int unsigned NUM_WR    = 2,
  parameter int unsigned NUM_AL    = 2,
  parameter bit          BYPASS    = 1'b1
) (
  input logic             clk,
  input logic             rst_n,
  prf_multiport_if.slave  bus
);

  logic [PHYS_REGS-1:0][DATA_W-1:0] data_q;
  logic [PHYS_REGS-1:0]             ready_q;
  logic                             wr_conflict_q;

  logic [NUM_WR-1:0] wr_hit_c;
  logic [NUM_AL-1:0] al_hit_c;
  logic              conflict_c;

  // p0 and out-of-range indices never touch state
  function automatic logic idx_ok(input logic [PREG_W-1:0] idx);
    return (idx != '0) && (32'(idx) < PHYS_REGS);
  endfunction

  // Qualify enables and detect two write ports hitting one register
  always_comb begin
    wr_hit_c   = '0;
    al_hit_c   = '0;
    conflict_c = 1'b0;
    for (int i = 0; i < NUM_WR; i++)
      wr_hit_c[i] = bus.wr_en[i] && idx_ok(bus.wr_addr[i*PREG_W +: PREG_W]);
    for (int j = 0; j < NUM_AL; j++)
      al_hit_c[j] = bus.al_en[j] && idx_ok(bus.al_addr[j*PREG_W +: PREG_W]);
    for (int i = 0; i < NUM_WR; i++)
      for (int k = i + 1; k < NUM_WR; k++)
        if (wr_hit_c[i] && wr_hit_c[k] &&
            (bus.wr_addr[i*PREG_W +: PREG_W] == bus.wr_addr[k*PREG_W +: PREG_W]))
          conflict_c = 1'b1;
  end

  // Writes in ascending port order so the highest port wins; allocs last so they win ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q        <= '0;
      ready_q       <= '1;
      wr_conflict_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_WR; i++) begin
        if (wr_hit_c[i]) begin
          data_q[bus.wr_addr[i*PREG_W +: PREG_W]]  <= bus.wr_data[i*DATA_W +: DATA_W];
          ready_q[bus.wr_addr[i*PREG_W +: PREG_W]] <= 1'b1;
        end
      end
      for (int j = 0; j < NUM_AL; j++) begin
        if (al_hit_c[j])
          ready_q[bus.al_addr[j*PREG_W +: PREG_W]] <= 1'b0;
      end
      if (conflict_c)
        wr_conflict_q <= 1'b1;
      else if (bus.conflict_clr)
        wr_conflict_q <= 1'b0;
    end
  end

  // Combinational read ports; bypass forwards writes only, never allocs
  always_comb begin
    bus.rd_data  = '0;
    bus.rd_ready = '1;
    for (int p = 0; p < NUM_RD; p++) begin
      if (rst_n && idx_ok(bus.rd_addr[p*PREG_W +: PREG_W])) begin
        bus.rd_data[p*DATA_W +: DATA_W] = data_q[bus.rd_addr[p*PREG_W +: PREG_W]];
        bus.rd_ready[p]                 = ready_q[bus.rd_addr[p*PREG_W +: PREG_W]];
        if (BYPASS) begin
          for (int w = 0; w < NUM_WR; w++) begin
            if (wr_hit_c[w] &&
                (bus.wr_addr[w*PREG_W +: PREG_W] == bus.rd_addr[p*PREG_W +: PREG_W])) begin
              bus.rd_data[p*DATA_W +: DATA_W] = bus.wr_data[w*DATA_W +: DATA_W];
              bus.rd_ready[p]                 = 1'b1;
            end
          end
        end
      end
    end
  end

  assign bus.wr_conflict = wr_conflict_q;

endmodule

// File: tb/tb_prf_multiport.sv
// Scoreboard bench for prf_multiport: directed scenarios then randomized
// traffic, checked against a per-register reference model.
`timescale 1ns/1ps
module tb_prf_multiport;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned PHYS_REGS   = 64;
  localparam int unsigned PREG_W      = 6;
  localparam int unsigned NUM_RD      = 4;
  localparam int unsigned NUM_WR      = 2;
  localparam int unsigned NUM_AL      = 2;
  localparam bit          BYPASS      = 1'b1;
  localparam int unsigned RAND_CYCLES = 10000;

  typedef struct packed {
    logic [NUM_RD-1:0][DATA_W-1:0] data;
    logic [NUM_RD-1:0]             ready;
    logic                          conflict;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  prf_multiport_if #(.DATA_W(DATA_W), .PHYS_REGS(PHYS_REGS), .PREG_W(PREG_W),
                     .NUM_RD(NUM_RD), .NUM_WR(NUM_WR), .NUM_AL(NUM_AL)) bus ();

  prf_multiport #(.DATA_W(DATA_W), .PHYS_REGS(PHYS_REGS), .PREG_W(PREG_W),
                  .NUM_RD(NUM_RD), .NUM_WR(NUM_WR), .NUM_AL(NUM_AL),
                  .BYPASS(BYPASS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Reference model: architectural contents of each register
  logic [DATA_W-1:0] m_data [PHYS_REGS];
  logic              m_rdy  [PHYS_REGS];
  logic              m_flag;

  exp_t  exp_q [$];
  string tag_q [$];
  event  sample_ev;
  int    checks   = 0;
  int    failures = 0;

  function automatic void chk(string tag, string what, logic [DATA_W-1:0] act,
                              logic [DATA_W-1:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s %s: got %h expected %h", tag, what, act, expv);
    end
  endfunction

  task automatic model_reset();
    for (int r = 0; r < PHYS_REGS; r++) begin
      m_data[r] = '0;
      m_rdy[r]  = 1'b1;
    end
    m_flag = 1'b0;
  endtask

  // Apply one clock edge to the model, register by register
  task automatic model_edge();
    bit any_conflict = 1'b0;
    for (int r = 1; r < PHYS_REGS; r++) begin
      int nw = 0;
      bit alloc = 1'b0;
      for (int w = 0; w < NUM_WR; w++)
        if (bus.wr_en[w] && int'(bus.wr_addr[w*PREG_W +: PREG_W]) == r) begin
          nw++;
          m_data[r] = bus.wr_data[w*DATA_W +: DATA_W];
        end
      for (int j = 0; j < NUM_AL; j++)
        if (bus.al_en[j] && int'(bus.al_addr[j*PREG_W +: PREG_W]) == r) alloc = 1'b1;
      if (alloc)       m_rdy[r] = 1'b0;
      else if (nw > 0) m_rdy[r] = 1'b1;
      if (nw > 1) any_conflict = 1'b1;
    end
    if (any_conflict)          m_flag = 1'b1;
    else if (bus.conflict_clr) m_flag = 1'b0;
  endtask

  function automatic exp_t predict();
    exp_t e;
    e.conflict = m_flag;
    for (int p = 0; p < NUM_RD; p++) begin
      int a = int'(bus.rd_addr[p*PREG_W +: PREG_W]);
      e.data[p]  = '0;
      e.ready[p] = 1'b1;
      if (rst_n && a != 0 && a < PHYS_REGS) begin
        e.data[p]  = m_data[a];
        e.ready[p] = m_rdy[a];
        if (BYPASS)
          for (int w = 0; w < NUM_WR; w++)
            if (bus.wr_en[w] && int'(bus.wr_addr[w*PREG_W +: PREG_W]) == a) begin
              e.data[p]  = bus.wr_data[w*DATA_W +: DATA_W];
              e.ready[p] = 1'b1;
            end
      end
    end
    return e;
  endfunction

  task automatic clr_inputs();
    bus.rd_addr      = '0;
    bus.wr_en        = '0;
    bus.wr_addr      = '0;
    bus.wr_data      = '0;
    bus.al_en        = '0;
    bus.al_addr      = '0;
    bus.conflict_clr = 1'b0;
  endtask

  task automatic set_rd(input int p, input int a);
    bus.rd_addr[p*PREG_W +: PREG_W] = PREG_W'(a);
  endtask

  task automatic set_wr(input int w, input int a, input logic [DATA_W-1:0] d);
    bus.wr_en[w]                    = 1'b1;
    bus.wr_addr[w*PREG_W +: PREG_W] = PREG_W'(a);
    bus.wr_data[w*DATA_W +: DATA_W] = d;
  endtask

  task automatic set_al(input int j, input int a);
    bus.al_en[j]                    = 1'b1;
    bus.al_addr[j*PREG_W +: PREG_W] = PREG_W'(a);
  endtask

  // Push expectation, let the monitor sample, then advance one edge
  task automatic step(input string tag);
    exp_q.push_back(predict());
    tag_q.push_back(tag);
    #2;
    -> sample_ev;
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
  endtask

  function automatic int rand_addr();
    return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, PHYS_REGS - 1))
                                       : int'($urandom_range(0, 7));
  endfunction

  // Monitor: compare every sampled cycle against the queued expectation
  initial begin
    exp_t  e;
    string t;
    forever begin
      @(sample_ev);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL monitor: got a sample with no expectation queued");
      end else begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        for (int p = 0; p < NUM_RD; p++) begin
          chk(t, $sformatf("rd_data[%0d]", p), bus.rd_data[p*DATA_W +: DATA_W], e.data[p]);
          chk(t, $sformatf("rd_ready[%0d]", p), DATA_W'(bus.rd_ready[p]), DATA_W'(e.ready[p]));
        end
        chk(t, "wr_conflict", DATA_W'(bus.wr_conflict), DATA_W'(e.conflict));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clr_inputs();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    step("por0");
    step("por1");
    rst_n = 1'b1;

    // Write then read, same cycle and next cycle
    clr_inputs(); set_wr(0, 5, 32'hDEAD_BEEF); set_rd(0, 5); step("wr_same");
    clr_inputs(); set_rd(0, 5); step("wr_next");

    // Alloc clears ready; later writeback sets it and data
    clr_inputs(); set_al(0, 9); set_rd(1, 9); step("al_same");
    clr_inputs(); set_rd(1, 9); step("al_busy");
    clr_inputs(); set_wr(1, 9, 32'h1234); set_rd(1, 9); step("wb_same");
    clr_inputs(); set_rd(1, 9); step("wb_next");

    // Alloc and write same register same edge
    clr_inputs(); set_al(0, 7); set_wr(0, 7, 32'hAA); set_rd(2, 7); step("alwr_same");
    clr_inputs(); set_rd(2, 7); step("alwr_next");

    // Write-port conflict, sticky hold, clear, set-over-clear
    clr_inputs(); set_wr(0, 3, 32'h11); set_wr(1, 3, 32'h22); set_rd(3, 3); step("cf_same");
    clr_inputs(); set_rd(3, 3); step("cf_set");
    clr_inputs(); set_rd(3, 3); step("cf_hold");
    clr_inputs(); bus.conflict_clr = 1'b1; step("cf_clr");
    clr_inputs(); step("cf_cleared");
    clr_inputs(); set_wr(0, 4, 32'h1); set_wr(1, 4, 32'h2); bus.conflict_clr = 1'b1; step("cf_prio");
    clr_inputs(); set_rd(0, 4); step("cf_prio_set");
    clr_inputs(); bus.conflict_clr = 1'b1; step("cf_clr2");

    // Both ports writing p0: ignored, no flag
    clr_inputs(); set_wr(0, 0, 32'h55); set_wr(1, 0, 32'h66); set_al(1, 0); set_rd(0, 0); step("p0_same");
    clr_inputs(); set_rd(0, 0); step("p0_next");

    // Async reset mid-cycle with traffic in flight
    clr_inputs(); set_wr(0, 3, 32'h77); set_wr(1, 3, 32'h88); set_al(0, 5);
    set_rd(0, 5); set_rd(1, 9); set_rd(2, 3); set_rd(3, 7);
    #1;
    rst_n = 1'b0;
    model_reset();
    step("rst_mid");
    step("rst_hold");
    rst_n = 1'b1;
    clr_inputs(); set_rd(0, 5); set_rd(1, 9); set_rd(2, 3); set_rd(3, 7); step("rst_after");

    // Randomized traffic on every port
    for (int c = 0; c < RAND_CYCLES; c++) begin
      clr_inputs();
      for (int p = 0; p < NUM_RD; p++) set_rd(p, rand_addr());
      for (int w = 0; w < NUM_WR; w++)
        if ($urandom_range(0, 1) == 1) set_wr(w, rand_addr(), $urandom());
      for (int j = 0; j < NUM_AL; j++)
        if ($urandom_range(0, 1) == 1) set_al(j, rand_addr());
      bus.conflict_clr = ($urandom_range(0, 15) == 0);
      step("rand");
    end

    clr_inputs();
    #5;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expectations expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
